// File: rtl/spi_pkg.sv
// Shared encodings for the SPI command decoder / register bank.
package spi_pkg;

   localparam int ADDR_W = 7;
   localparam int CMD_WR_BIT = 7;
   localparam logic [ADDR_W-1:0] ID_ADDR = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_bank.sv
// Byte-framed read/write register bank behind a mode-0 SPI slave, with
// address auto-increment; CS high ends the frame.
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter logic [7:0]  ID_VALUE = 8'hA5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_spi_cs,
   input  logic [7:0]            i_rx_byte,
   input  logic                  i_rx_dv,
   output logic [7:0]            o_tx_byte,
   output logic                  o_tx_dv,
   output logic [NUM_REGS*8-1:0] o_regs_out,
   output logic                  o_wr_stb,
   output logic [ADDR_W-1:0]     o_wr_addr
);

   logic                  w_cs_s;
   logic                  w_rx_evt;
   logic [ADDR_W-1:0]     w_rd_addr;
   logic [7:0]            w_rd_data;
   logic                  w_wr_hit;

   logic                  r_rx_dv_q;
   state_e                r_state;
   logic [ADDR_W-1:0]     r_ptr;
   logic [NUM_REGS*8-1:0] r_regs;
   logic [7:0]            r_tx_byte;
   logic                  r_tx_dv;
   logic                  r_wr_stb;
   logic [ADDR_W-1:0]     r_wr_addr;

   // Reset to 1 so the frame is inactive until CS is seen low after reset.
   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_cs_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_spi_cs),
      .o_q     (w_cs_s)
   );

   assign w_rx_evt = i_rx_dv & ~r_rx_dv_q;

   // In IDLE the command byte addresses the read; in READ it is the next pointer.
   always_comb begin
      w_rd_addr = (r_state == IDLE) ? i_rx_byte[ADDR_W-1:0] : r_ptr + 7'd1;
      w_rd_data = 8'h00;
      if (w_rd_addr == ID_ADDR) w_rd_data = ID_VALUE;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (w_rd_addr == ADDR_W'(n)) w_rd_data = r_regs[n*8 +: 8];
      end
      w_wr_hit = 1'b0;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (r_ptr == ADDR_W'(n)) w_wr_hit = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_dv_q <= 1'b0;
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_regs    <= '0;
         r_tx_byte <= 8'h00;
         r_tx_dv   <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_wr_addr <= '0;
      end else begin
         r_rx_dv_q <= i_rx_dv;
         r_tx_dv   <= 1'b0;
         r_wr_stb  <= 1'b0;
         if (w_cs_s) begin
            r_state   <= IDLE;
            r_tx_byte <= 8'h00;
         end else if (w_rx_evt) begin
            unique case (r_state)
               IDLE: begin
                  r_ptr <= i_rx_byte[ADDR_W-1:0];
                  if (i_rx_byte[CMD_WR_BIT]) begin
                     r_state <= WRITE;
                  end else begin
                     r_state   <= READ;
                     r_tx_byte <= w_rd_data;
                     r_tx_dv   <= 1'b1;
                  end
               end
               WRITE: begin
                  for (int n = 0; n < NUM_REGS; n++) begin
                     if (r_ptr == ADDR_W'(n)) r_regs[n*8 +: 8] <= i_rx_byte;
                  end
                  if (w_wr_hit) begin
                     r_wr_stb  <= 1'b1;
                     r_wr_addr <= r_ptr;
                  end
                  r_ptr <= r_ptr + 7'd1;
               end
               READ: begin
                  r_ptr     <= r_ptr + 7'd1;
                  r_tx_byte <= w_rd_data;
                  r_tx_dv   <= 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_tx_byte  = r_tx_byte;
   assign o_tx_dv    = r_tx_dv;
   assign o_regs_out = r_regs;
   assign o_wr_stb   = r_wr_stb;
   assign o_wr_addr  = r_wr_addr;

endmodule
